multicycle_memory: RTL
======================

Name: multicycle_memory

Overview:
- Word-organised data/instruction memory that responds to the CPU pipeline (and, later, the cache fill logic) with a fixed multi-cycle read latency.
- It is the responder end of the enable/wr/addr/data_in request interface that the pipeline's memory stage drives.
- Requests are pipelined: one request can be accepted per cycle.
- Read data returns LATENCY cycles after the request, qualified by a one-cycle data_valid pulse.

Parameters:
- ADDR_WIDTH, 16, byte-address width; the array holds 2^(ADDR_WIDTH-1) 16-bit words.
- LATENCY, 4, cycles from read acceptance to data_valid; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  request strobe; a request is accepted on a rising edge where enable=1.
- wr  input  1  1 = write request, 0 = read request; ignored when enable=0.
- addr  input  ADDR_WIDTH  byte address; word index = addr[ADDR_WIDTH-1:1]; addr[0] is ignored.
- data_in  input  16  write data.
- data_out  output  16  read data; valid only while data_valid=1.
- data_valid  output  1  one-cycle pulse per completed read.
- busy  output  1  request-acceptance blocked; constant 0 unless MEM_BUSY_EN is defined.

Behaviour:
- Reset:
  - rst=1 at a clock edge clears the entire read-return pipe.
  - data_valid=0, data_out=16'h0000, busy=0.
  - The array contents are NOT cleared.
  - Requests presented while rst=1 are ignored, including writes.
- Write (enable=1, wr=1):
  - The array word is updated at the accepting edge.
  - No data_valid is produced for a write.
- Read (enable=1, wr=0):
  - The array word is sampled at the accepting edge into pipe stage 0.
  - The sample includes every write accepted at earlier edges.
  - A read accepted at edge t drives data_valid=1 and data_out=word during the cycle after edge t+LATENCY-1. Equivalently, it is visible LATENCY cycles after the request cycle.
- Read-after-write, same address:
  - Write at edge t followed by read at edge t+1 returns the new data.
  - There is no internal forwarding case, because only one request is accepted per cycle.
- Back-to-back reads:
  - N consecutive read cycles produce N consecutive data_valid pulses, in request order, with no gaps.
- Pipe structure:
  - LATENCY stages, each holding {valid, data[15:0]}.
  - The pipe shifts every cycle; there is no stalling from the requester side.
  - data_out is 16'h0000 whenever data_valid=0; no stale data is exposed.
- Reset mid-operation: in-flight reads are dropped, and no data_valid ever appears for them.
- Address wrap: there is none. Address bits above ADDR_WIDTH-1 do not exist.

Optional Feature:
- Macro: MEM_BUSY_EN.
- Defined: non-pipelined responder.
  - busy rises in the cycle after a read is accepted.
  - busy stays high until the cycle in which data_valid=1, and falls together with the data_valid pulse.
  - Any request (read or write) presented while busy=1 is ignored: no write, no response.
  - Writes never assert busy.
- Not defined:
  - busy is tied to 0.
  - The fully pipelined behaviour above applies.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_WIDTH=16;
  - DEFAULT_MEM_LATENCY=4;
  - the typedef of a pipe entry {logic valid; logic [15:0] data}.
- One sub-module is natural: mem_return_pipe.
  - Parameterised LATENCY shift register of pipe entries.
  - Synchronous active-high clear.
  - Input {valid, data}; output tail entry.
- multicycle_memory instantiates the array plus one mem_return_pipe. Under MEM_BUSY_EN it also contains a 2-state FSM: IDLE, WAIT_RD.
  - IDLE -> WAIT_RD on an accepted read.
  - WAIT_RD -> IDLE when the pipe tail is valid.
  - rst forces IDLE.

Test Plan:
- Single read latency:
  - Stimulus: write 16'hBEEF to addr 16'h0010, then read 16'h0010 at edge t.
  - Response: data_valid=1 with data_out=16'hBEEF only in the cycle after edge t+3 (LATENCY=4); data_valid=0 in all other cycles.
- Streamed reads:
  - Stimulus: preload addrs 0x0,0x2,0x4,0x6 with 1,2,3,4, then issue 4 consecutive reads.
  - Response: 4 consecutive data_valid pulses carrying 1,2,3,4 in order.
- Read-after-write and odd address:
  - Stimulus: write 16'h1234 to addr 0x0021, then read addr 0x0020 on the next cycle.
  - Response: returns 16'h1234, because addr[0] is ignored.
- Reset mid-flight:
  - Stimulus: read issued, then rst=1 for 1 cycle two cycles later.
  - Response: no data_valid pulse for that read.
  - Stimulus: a write presented during rst.
  - Response: it is lost; the array keeps its prior value.
- Write produces no response:
  - Stimulus: 10 consecutive writes.
  - Response: data_valid stays 0 and data_out stays 16'h0000 throughout.
- MEM_BUSY_EN:
  - Stimulus: read A=16'h0100 at edge t, then read B on every cycle while busy=1.
  - Response: busy=1 for cycles t+1..t+4; exactly one data_valid, carrying A's word; B is ignored until busy falls.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the multi-cycle memory: word width, default latency, return-pipe entry.
// Also holds the responder state encoding used when MEM_BUSY_EN is defined.
package mem_pkg;

  localparam int WORD_WIDTH          = 16;
  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] data;
  } mem_entry_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } rd_state_t;

endpackage

// File: rtl/mem_return_pipe.sv
// Fixed-depth shift register of {valid, data} entries; LATENCY cycles input to tail.
// No backpressure: shifts every cycle, synchronous active-high clear empties it.
module mem_return_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic       clk,
  input  logic       clr,
  input  mem_entry_t in_entry,
  output mem_entry_t out_entry
);

  mem_entry_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_entry;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_entry = stage[LATENCY-1];

endmodule

// File: rtl/multicycle_memory.sv
// Word memory responder: reads return after LATENCY cycles with a data_valid pulse, writes are silent.
// No backpressure unless MEM_BUSY_EN is defined, which makes it accept one read at a time via busy.
module multicycle_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = DEFAULT_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 1);

  logic [WORD_WIDTH-1:0] mem [WORDS];
  logic [ADDR_WIDTH-2:0] word_idx;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  unused_addr_lsb;
  mem_entry_t            pipe_in;
  mem_entry_t            pipe_out;

  assign word_idx        = addr[ADDR_WIDTH-1:1];
  assign unused_addr_lsb = addr[0];

`ifdef MEM_BUSY_EN
  rd_state_t state;

  assign accept = enable && !rst && (state == ST_IDLE);

  // Leaves WAIT_RD on the edge that ends the data_valid cycle, so busy drops with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (rd_accept) state <= ST_WAIT_RD;
        ST_WAIT_RD: if (pipe_out.valid) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_WAIT_RD);
`else
  assign accept = enable && !rst;
  assign busy   = 1'b0;
`endif

  assign rd_accept = accept && !wr;
  assign wr_accept = accept && wr;

  always_ff @(posedge clk) begin
    if (wr_accept) mem[word_idx] <= data_in;
  end

  // Invalid entries carry zero data so data_out never shows stale words.
  assign pipe_in = {rd_accept, rd_accept ? mem[word_idx] : {WORD_WIDTH{1'b0}}};

  mem_return_pipe #(
    .LATENCY(LATENCY)
  ) u_return_pipe (
    .clk      (clk),
    .clr      (rst),
    .in_entry (pipe_in),
    .out_entry(pipe_out)
  );

  assign data_valid = pipe_out.valid;
  assign data_out   = pipe_out.data;

endmodule
